// File: rtl/wb_port_sched_pkg.sv
// Shared definitions for the write-back port scheduler: FSM encodings and parameter defaults.
package wb_port_sched_pkg;

  typedef enum logic [0:0] {
    WBS_IDLE     = 1'b0,
    WBS_MEM_WAIT = 1'b1
  } wbs_state_e;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_AW_DEF     = 3;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/wb_port_sched_chk.sv
// Protocol checks for the write-back port scheduler.
module wb_port_sched_chk (
  input logic clk,
  input logic rst_n,
  input logic in_mem_wait,
  input logic wb_valid,
  input logic mc_ack,
  input logic pipe_gnt
);

  a_valid_held_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    in_mem_wait |-> wb_valid)
    else $error("wb_valid dropped while a load was pending");

  a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(mc_ack && pipe_gnt))
    else $error("both requesters granted in one cycle");

endmodule

// File: rtl/wb_port_sched_starve_cnt.sv
// Saturating 4-bit count of consecutive cycles the multi-cycle request lost arbitration.
module wb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear dominates, increment saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/wb_port_sched.sv
// Register-file write-port scheduler: sequences late loads and arbitrates the
// in-order WB instruction against the multi-cycle unit with a starvation bound.
module wb_port_sched
  import wb_port_sched_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_AW     = REG_AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mc_req,
  input  logic [REG_AW-1:0] mc_dest,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ack,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  wbs_state_e        state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic pipe_rdy_s, starve_hit_s, mc_win_s, pipe_gnt_s, load_wait_s;
  logic cnt_inc_s, cnt_clr_s;

  // Grant decision; MC only beats a ready pipeline once it has lost STARVE_MAX times in a row.
  always_comb begin
    pipe_rdy_s  = wb_valid & wb_reg_write & (~wb_mem_to_reg | mem_done);
    load_wait_s = wb_valid & wb_reg_write & wb_mem_to_reg & ~mem_done;
    mc_win_s    = mc_req & (~pipe_rdy_s | starve_hit_s);
    pipe_gnt_s  = pipe_rdy_s & ~mc_win_s;
    cnt_inc_s   = mc_req & ~mc_win_s;
    cnt_clr_s   = ~mc_req | mc_win_s;
  end

  assign mc_ack   = rst_n & mc_win_s;
  assign wb_stall = rst_n & wb_valid & wb_reg_write & ~pipe_gnt_s;

  wb_starve_cnt #(.LIMIT(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc_s),
    .clr   (cnt_clr_s),
    .hit   (starve_hit_s)
  );

  // FSM next state: wait for late load data, return once the load write is granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WBS_IDLE: begin
        if (load_wait_s) begin
          state_d = WBS_MEM_WAIT;
        end else begin
          state_d = WBS_IDLE;
        end
      end
      WBS_MEM_WAIT: begin
        if (pipe_gnt_s) begin
          state_d = WBS_IDLE;
        end else begin
          state_d = WBS_MEM_WAIT;
        end
      end
      default: state_d = WBS_IDLE;
    endcase
  end

  // Write-port capture; address/data hold when nothing is granted.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_gnt_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_dest;
      rf_wdata_d = wb_mem_to_reg ? mem_rdata : wb_alu_result;
    end else if (mc_win_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mc_dest;
      rf_wdata_d = mc_data;
    end else begin
      rf_we_d    = 1'b0;
    end
  end

  // FSM state and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WBS_IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  wb_port_sched_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_mem_wait (state_q == WBS_MEM_WAIT),
    .wb_valid    (wb_valid),
    .mc_ack      (mc_ack),
    .pipe_gnt    (pipe_gnt_s)
  );

endmodule
